// File: rtl/npc_pkg.sv
// Shared NPC definitions: CSR indices, trap cause codes and the write-back FSM states.
package npc_pkg;

  localparam logic [1:0]  CSR_MSTATUS    = 2'd0;
  localparam logic [1:0]  CSR_MTVEC      = 2'd1;
  localparam logic [1:0]  CSR_MEPC       = 2'd2;
  localparam logic [1:0]  CSR_MCAUSE     = 2'd3;
  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
  localparam logic [31:0] MSTATUS_RST    = 32'h0000_1800;

  typedef enum logic [1:0] {
    WBU_IDLE,
    WBU_COMMIT,
    WBU_REDIRECT
  } wbu_state_e;

endpackage

// File: rtl/regfile.sv
// General-purpose register file: one synchronous write port, two combinational
// read ports, x0 hardwired to zero.
module regfile #(
  parameter int NR_REG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [NR_REG];

  generate
    for (genvar gi = 0; gi < NR_REG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi] = '0;
      end else begin : g_entry
        always_ff @(posedge clk) begin
          if (rst) begin
            regs[gi] <= '0;
          end else if (we && waddr == 5'(gi)) begin
            regs[gi] <= wdata;
          end
        end
      end
    end
  endgenerate

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/wbu.sv
// Write-back stage: latches one retiring instruction, commits GPR/CSR results
// (including ecall trap entry) and hands the next PC to the IFU.
module wbu
  import npc_pkg::*;
#(
  parameter int          NR_REG      = 32,
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbu_receive_valid,
  input  logic [31:0] wd_input,
  input  logic [31:0] csr_wd_input,
  input  logic [4:0]  rd_input,
  input  logic [1:0]  csr_rd_input,
  input  logic        reg_write_en_input,
  input  logic        csreg_write_en_input,
  input  logic        ecall_input,
  input  logic [31:0] pc_input,
  input  logic [31:0] pc_next_input,
  input  logic [31:0] instruction_input,
  input  logic        ifu_receive_ready,
  output logic        wbu_send_valid,
  output logic [31:0] pc_next,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic [1:0]  csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        wbu_state
);

  wbu_state_e state_reg, state_next;

  logic [31:0] wd_reg, csr_wd_reg;
  logic [4:0]  rd_reg;
  logic [1:0]  csr_rd_reg;
  logic        reg_we_reg, csr_we_reg, ecall_reg;
  logic [31:0] mstatus_reg, mtvec_reg, mepc_reg, mcause_reg;

  logic accept, commit, gpr_we;

  assign accept = (state_reg == WBU_IDLE) && wbu_receive_valid;
  assign commit = (state_reg == WBU_COMMIT);
  assign gpr_we = commit && !rst && reg_we_reg && (rd_reg != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= WBU_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    wbu_send_valid = 1'b0;
    case (state_reg)
      WBU_IDLE:   if (wbu_receive_valid) state_next = WBU_COMMIT;
      WBU_COMMIT: state_next = WBU_REDIRECT;
      WBU_REDIRECT: begin
        wbu_send_valid = 1'b1;
        if (ifu_receive_ready) state_next = WBU_IDLE;
      end
      default:    state_next = WBU_IDLE;
    endcase
  end

  // Busy from the accepting cycle through the handshake cycle inclusive.
  assign wbu_state = (state_reg != WBU_IDLE) || (state_next != WBU_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_reg      <= '0;
      csr_wd_reg  <= '0;
      rd_reg      <= '0;
      csr_rd_reg  <= '0;
      reg_we_reg  <= 1'b0;
      csr_we_reg  <= 1'b0;
      ecall_reg   <= 1'b0;
      pc          <= '0;
      instruction <= '0;
      pc_next     <= '0;
    end else if (accept) begin
      wd_reg      <= wd_input;
      csr_wd_reg  <= csr_wd_input;
      rd_reg      <= rd_input;
      csr_rd_reg  <= csr_rd_input;
      reg_we_reg  <= reg_write_en_input;
      csr_we_reg  <= csreg_write_en_input;
      ecall_reg   <= ecall_input;
      pc          <= pc_input;
      instruction <= instruction_input;
      pc_next     <= pc_next_input;
    end else if (commit && ecall_reg) begin
      pc_next     <= mtvec_reg;
    end
  end

  // A trap takes priority over any explicit CSR write of the same instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_reg <= MSTATUS_RST;
      mtvec_reg   <= '0;
      mepc_reg    <= '0;
      mcause_reg  <= '0;
    end else if (commit) begin
      if (ecall_reg) begin
        mepc_reg   <= pc;
        mcause_reg <= MCAUSE_ECALL_M;
      end else if (csr_we_reg) begin
        case (csr_rd_reg)
          CSR_MSTATUS: mstatus_reg <= csr_wd_reg;
          CSR_MTVEC:   mtvec_reg   <= csr_wd_reg;
          CSR_MEPC:    mepc_reg    <= csr_wd_reg;
          default:     mcause_reg  <= csr_wd_reg;
        endcase
      end
    end
  end

  always_comb begin
    csr_rdata = mstatus_reg;
    case (csr_raddr)
      CSR_MTVEC:  csr_rdata = mtvec_reg;
      CSR_MEPC:   csr_rdata = mepc_reg;
      CSR_MCAUSE: csr_rdata = mcause_reg;
      default:    csr_rdata = mstatus_reg;
    endcase
  end

  regfile #(.NR_REG(NR_REG)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (gpr_we),
    .waddr  (rd_reg),
    .wdata  (wd_reg),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

endmodule

// File: tb/tb_wbu.sv
// Self-checking bench for wbu: directed scenarios plus randomized retirements
// checked against an architectural model of the GPRs, CSRs and next-PC.
module tb_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbu_receive_valid;
  logic [31:0] wd_input, csr_wd_input, pc_input, pc_next_input, instruction_input;
  logic [4:0]  rd_input;
  logic [1:0]  csr_rd_input;
  logic        reg_write_en_input, csreg_write_en_input, ecall_input;
  logic        ifu_receive_ready;
  logic        wbu_send_valid;
  logic [31:0] pc_next, instruction, pc;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic [1:0]  csr_raddr;
  logic [31:0] csr_rdata;
  logic        wbu_state;

  int total = 0;
  int bad   = 0;

  logic [31:0] gpr_m [32];
  logic [31:0] csr_m [4];

  always #5 clk = ~clk;

  wbu dut (
    .clk                  (clk),
    .rst                  (rst),
    .wbu_receive_valid    (wbu_receive_valid),
    .wd_input             (wd_input),
    .csr_wd_input         (csr_wd_input),
    .rd_input             (rd_input),
    .csr_rd_input         (csr_rd_input),
    .reg_write_en_input   (reg_write_en_input),
    .csreg_write_en_input (csreg_write_en_input),
    .ecall_input          (ecall_input),
    .pc_input             (pc_input),
    .pc_next_input        (pc_next_input),
    .instruction_input    (instruction_input),
    .ifu_receive_ready    (ifu_receive_ready),
    .wbu_send_valid       (wbu_send_valid),
    .pc_next              (pc_next),
    .instruction          (instruction),
    .pc                   (pc),
    .raddr1               (raddr1),
    .raddr2               (raddr2),
    .rdata1               (rdata1),
    .rdata2               (rdata2),
    .csr_raddr            (csr_raddr),
    .csr_rdata            (csr_rdata),
    .wbu_state            (wbu_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) gpr_m[i] = '0;
    csr_m[0] = 32'h0000_1800;
    csr_m[1] = '0;
    csr_m[2] = '0;
    csr_m[3] = '0;
  endtask

  task automatic scramble_inputs();
    wd_input             = $urandom;
    csr_wd_input         = $urandom;
    rd_input             = 5'($urandom);
    csr_rd_input         = 2'($urandom);
    reg_write_en_input   = 1'($urandom);
    csreg_write_en_input = 1'($urandom);
    ecall_input          = 1'($urandom);
    pc_input             = $urandom;
    pc_next_input        = $urandom;
    instruction_input    = $urandom;
  endtask

  task automatic dump_check();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      raddr1    = 5'(i);
      raddr2    = 5'(31 - i);
      csr_raddr = 2'(i);
      #1;
      check($sformatf("gpr_r1[%0d]", i), rdata1, gpr_m[i]);
      check($sformatf("gpr_r2[%0d]", 31 - i), rdata2, gpr_m[31 - i]);
      if (i < 4) check($sformatf("csr[%0d]", i), csr_rdata, csr_m[i]);
    end
  endtask

  // One retirement: valid pulse, COMMIT, REDIRECT held for `stall` cycles, back to IDLE.
  task automatic run_txn(input logic [4:0] rd, input logic [31:0] wd, input logic we,
                         input logic cwe, input logic [1:0] crd, input logic [31:0] cwd,
                         input logic ecall, input logic [31:0] pc_i,
                         input logic [31:0] pn_i, input logic [31:0] ins, input int stall);
    logic [31:0] exp_pn;
    logic [1:0]  cview;
    cview = ecall ? 2'd2 : crd;
    @(negedge clk);
    wbu_receive_valid    = 1'b1;
    rd_input             = rd;
    wd_input             = wd;
    reg_write_en_input   = we;
    csreg_write_en_input = cwe;
    csr_rd_input         = crd;
    csr_wd_input         = cwd;
    ecall_input          = ecall;
    pc_input             = pc_i;
    pc_next_input        = pn_i;
    instruction_input    = ins;
    ifu_receive_ready    = (stall == 0);
    raddr1               = rd;
    raddr2               = 5'd0;
    csr_raddr            = cview;
    #1;
    check("state_on_valid", 32'(wbu_state), 32'd1);
    check("send_valid_idle", 32'(wbu_send_valid), 32'd0);

    // COMMIT cycle: read ports still show pre-commit contents.
    @(negedge clk);
    wbu_receive_valid = 1'b0;
    scramble_inputs();
    #1;
    check("send_valid_commit", 32'(wbu_send_valid), 32'd0);
    check("state_commit", 32'(wbu_state), 32'd1);
    check("gpr_old_in_commit", rdata1, gpr_m[rd]);
    check("csr_old_in_commit", csr_rdata, csr_m[cview]);
    check("x0_read", rdata2, 32'd0);

    if (ecall) begin
      exp_pn   = csr_m[1];
      csr_m[2] = pc_i;
      csr_m[3] = 32'd11;
    end else begin
      exp_pn = pn_i;
      if (cwe) csr_m[crd] = cwd;
    end
    if (we && rd != 5'd0) gpr_m[rd] = wd;

    for (int k = 0; k <= stall; k++) begin
      @(negedge clk);
      #1;
      check("send_valid_redirect", 32'(wbu_send_valid), 32'd1);
      check("pc_next", pc_next, exp_pn);
      check("pc", pc, pc_i);
      check("instruction", instruction, ins);
      check("gpr_new", rdata1, gpr_m[rd]);
      check("csr_new", csr_rdata, csr_m[cview]);
      if (k < stall) check("state_stall", 32'(wbu_state), 32'd1);
      if (k == stall) ifu_receive_ready = 1'b1;
    end

    @(negedge clk);
    ifu_receive_ready = 1'b0;
    #1;
    check("send_valid_after", 32'(wbu_send_valid), 32'd0);
    check("state_idle", 32'(wbu_state), 32'd0);
    $display("txn rd=%0d wd=%h we=%0d cwe=%0d crd=%0d ecall=%0d pc=%h pc_next=%h stall=%0d",
             rd, wd, we, cwe, crd, ecall, pc_i, exp_pn, stall);
  endtask

  initial begin
    rst               = 1'b1;
    wbu_receive_valid = 1'b0;
    ifu_receive_ready = 1'b0;
    raddr1            = '0;
    raddr2            = '0;
    csr_raddr         = '0;
    scramble_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_send_valid", 32'(wbu_send_valid), 32'd0);
    check("reset_pc_next", pc_next, 32'd0);
    check("reset_pc", pc, 32'd0);
    check("reset_instruction", instruction, 32'd0);
    check("reset_state", 32'(wbu_state), 32'd0);
    dump_check();

    run_txn(5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0,
            32'h8000_0000, 32'h8000_0004, 32'h0000_0013, 0);
    run_txn(5'd0, 32'h0000_1234, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0,
            32'h8000_0004, 32'h8000_0008, 32'h0000_0013, 0);
    run_txn(5'd1, 32'h0, 1'b0, 1'b1, 2'd1, 32'h8000_0100, 1'b0,
            32'h8000_0008, 32'h8000_000C, 32'h3051_1073, 0);
    run_txn(5'd2, 32'hAAAA_5555, 1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 1'b1,
            32'h8000_0020, 32'h8000_0024, 32'h0000_0073, 4);
    check("mepc_after_ecall", csr_m[2], 32'h8000_0020);

    // Reset during COMMIT must drop the pending write to x7.
    @(negedge clk);
    wbu_receive_valid    = 1'b1;
    rd_input             = 5'd7;
    wd_input             = 32'h55;
    reg_write_en_input   = 1'b1;
    csreg_write_en_input = 1'b1;
    csr_rd_input         = 2'd1;
    csr_wd_input         = 32'h1234_5678;
    ecall_input          = 1'b0;
    @(negedge clk);
    wbu_receive_valid = 1'b0;
    rst               = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    raddr1    = 5'd7;
    csr_raddr = 2'd1;
    model_reset();
    #1;
    check("rst_mid_x7", rdata1, 32'd0);
    check("rst_mid_mtvec", csr_rdata, 32'd0);
    check("rst_mid_send_valid", 32'(wbu_send_valid), 32'd0);
    check("rst_mid_state", 32'(wbu_state), 32'd0);
    @(negedge clk);
    #1;
    check("rst_mid_stays_idle", 32'(wbu_send_valid), 32'd0);

    for (int n = 0; n < 40; n++) begin
      run_txn(5'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 2) == 0),
              2'($urandom), $urandom, ($urandom_range(0, 4) == 0),
              $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
    end
    dump_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wbu.md
# wbu

Write-back stage of the NPC multicycle core, directly downstream of the LSU. It captures one retiring instruction per LSU valid pulse and commits its GPR and CSR results. It handles `ecall` trap entry and hands the architecturally correct next PC to the IFU over a valid/ready handshake. It owns the 32×32 GPR file and the machine CSRs, and gives the IDU combinational read ports into both.

## Interface
- `NR_REG`, default 32: GPR count; index width is 5.
- `MSTATUS_RST`, default 32'h0000_1800: `mstatus` reset value.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `wbu_receive_valid` in 1: one-cycle pulse from the LSU; the instruction is retiring.
- `wd_input` in 32: GPR write data.
- `csr_wd_input` in 32: CSR write data.
- `rd_input` in 5: destination GPR.
- `csr_rd_input` in 2: destination CSR. 00 `mstatus`, 01 `mtvec`, 10 `mepc`, 11 `mcause`.
- `reg_write_en_input` in 1: GPR write enable.
- `csreg_write_en_input` in 1: CSR write enable.
- `ecall_input` in 1: instruction is `ecall`.
- `pc_input` in 32: PC of the instruction.
- `pc_next_input` in 32: next PC as computed upstream.
- `instruction_input` in 32: instruction word.
- `ifu_receive_ready` in 1: IFU accepts the next PC.
- `wbu_send_valid` out 1: next PC is valid.
- `pc_next` out 32: next PC to fetch.
- `instruction` out 32: retired instruction, for trace/difftest.
- `pc` out 32: retired PC.
- `raddr1`, `raddr2` in 5: IDU GPR read addresses.
- `rdata1`, `rdata2` out 32: GPR read data.
- `csr_raddr` in 2: IDU CSR read address.
- `csr_rdata` out 32: CSR read data.
- `wbu_state` out 1: high whenever `next_state != IDLE`.

## Operation
- The FSM has three states: IDLE, COMMIT, REDIRECT.
- **IDLE**
  - If `wbu_receive_valid` is high, latch every `*_input` and go to COMMIT.
  - Otherwise stay in IDLE.
- **COMMIT** (always exactly one cycle, then REDIRECT). At the closing edge:
  - GPR: if `reg_write_en` and `rd != 0`, then `gpr[rd] <= wd`. Writes to x0 are discarded, so x0 always reads 0.
  - If `ecall`:
    - `mepc <= pc`.
    - `mcause <= 32'd11`.
    - `pc_next <= mtvec`, using the value before the edge.
    - `csreg_write_en` and `csr_rd` are ignored.
  - Else if `csreg_write_en`: `csr[csr_rd] <= csr_wd`.
  - Else: `pc_next` keeps the latched `pc_next_input`.
  - The GPR write and the CSR/trap update occur in the same cycle and are independent.
- **REDIRECT**
  - `wbu_send_valid` = 1, with `pc_next`, `pc` and `instruction` stable.
  - When `wbu_send_valid && ifu_receive_ready`: go to IDLE, and `wbu_send_valid` drops the next cycle.
  - Otherwise hold every output and stay in REDIRECT.
- **Reads**
  - `rdata1/2` and `csr_rdata` are purely combinational from current register contents.
  - There is no write-to-read bypass. A read in the same cycle as the COMMIT edge returns the old value.
- **`wbu_receive_valid` outside IDLE** is ignored. Upstream never issues one while `wbu_state` is high.

## Timing
- **Reset values:**
  - `wbu_send_valid` = 0.
  - `pc_next`, `pc`, `instruction` = 0.
  - All GPRs = 0.
  - `mtvec`, `mepc`, `mcause` = 0.
  - `mstatus` = `MSTATUS_RST`.
  - FSM = IDLE.
- **Reset mid-operation** (COMMIT or REDIRECT): return to IDLE on the next edge. A pending commit is dropped and nothing is written.
- **Latency:**
  - Valid pulse in cycle T.
  - COMMIT in T+1.
  - Writes visible on read ports in T+2.
  - `wbu_send_valid` high from T+2.
- **Minimum occupancy:** IDLE to IDLE is 3 cycles when `ifu_receive_ready` is already high.
- **`wbu_state`:**
  - High from the cycle the valid pulse is seen through the REDIRECT handshake cycle.
  - Low in IDLE without valid.
- **Widths:** all data is 32-bit. No arithmetic except the `rd != 0` compare.

## Structure
- Shared package `npc_pkg`:
  - CSR index constants `CSR_MSTATUS`/`MTVEC`/`MEPC`/`MCAUSE` = 0..3.
  - `MCAUSE_ECALL_M` = 11.
  - `MSTATUS_RST` = 32'h1800.
  - WBU state enum.
- Sub-module `regfile`:
  - 32×32, one synchronous write port, two combinational read ports, x0 hardwired to zero.
  - Instantiated once.
- CSRs stay in `wbu` as four registers plus a read mux.

## Test plan
- Reset, then read all GPRs and CSRs -> GPRs 0, `mstatus` = 32'h1800, others 0; `wbu_send_valid` = 0.
- Pulse with `rd`=5, `wd`=32'hDEAD_BEEF, `reg_write_en`=1, `pc_next_input`=32'h8000_0004, `ifu_receive_ready`=1:
  - `rdata1` (`raddr1`=5) reads DEADBEEF from T+2.
  - `wbu_send_valid` pulses in T+2 with `pc_next`=32'h8000_0004.
  - Back in IDLE at T+3.
- Pulse with `rd`=0, `wd`=32'h1234, `reg_write_en`=1 -> x0 still reads 0.
- CSR write then trap:
  - Write `mtvec`=32'h8000_0100 via `csreg_write_en`.
  - Then pulse `ecall_input`=1 with `pc_input`=32'h8000_0020.
  - Expect `mepc`=32'h8000_0020, `mcause`=11, `pc_next`=32'h8000_0100.
- Hold `ifu_receive_ready`=0 for 4 cycles in REDIRECT -> `wbu_send_valid` and `pc_next` stay stable and `wbu_state`=1; exit one cycle after ready rises.
- Assert `rst` during COMMIT of a write to x7=32'h55 -> x7 stays 0, FSM is in IDLE, `wbu_send_valid` = 0.
